inst_line_responder: RTL and testbench
======================================

Name: inst_line_responder

Overview:
Responder end of the IF-stage instruction fetch interface. It accepts inst_read/inst_addr from the fetch stage and returns inst_rdata with inst_resp. It serves hits from a single 256-bit line buffer. On a miss it fetches the line from physical memory over a burst-read interface that delivers BEATS beats per line.

Parameters:
BEAT_W, 64, width of one physical-memory beat in bits (power of 2, >= 32)
BEATS, 4, beats per line (power of 2, >= 2); line = BEAT_W*BEATS bits = 32 bytes at defaults

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
inst_read  input  1  fetch request valid
inst_addr  input  32  fetch byte address; bits [1:0] ignored
inst_rdata  output  32  instruction word; valid only when inst_resp=1
inst_resp  output  1  request served this cycle
pmem_read  output  1  burst read request to physical memory
pmem_address  output  32  line-aligned burst address; low log2(line bytes) bits zero
pmem_rdata  input  BEAT_W  burst beat data
pmem_resp  input  1  one beat valid on pmem_rdata this cycle

Behaviour:
- Reset (async, active-high): state=IDLE, line_valid=0, tag=0, beat_cnt=0, pmem_read=0, pmem_address=0, inst_resp=0, inst_rdata=0.
- OFF = log2(BEAT_W*BEATS/8). Tag = inst_addr[31:OFF]. Word index = inst_addr[OFF-1:2].
- Hit = state==IDLE && inst_read && line_valid && tag matches.
- IDLE:
  - On hit, inst_resp=1 combinationally, same cycle. inst_rdata = line[32*idx +: 32]. 0-cycle hit latency.
  - On inst_read with no hit: inst_resp=0. Register pmem_address = {tag, OFF'b0}, set pmem_read=1, clear beat_cnt, go to FETCH.
  - Without inst_read: inst_resp=0 and inst_rdata=0.
- FETCH:
  - pmem_read stays 1 and pmem_address stays constant. inst_resp=0.
  - Each cycle with pmem_resp=1, write pmem_rdata into line[BEAT_W*beat_cnt +: BEAT_W] and increment beat_cnt. Beat 0 is the lowest-addressed beat.
  - On the beat with beat_cnt==BEATS-1: set line_valid=1, load tag from the registered pmem_address, drop pmem_read the next cycle, and go to IDLE.
- line_valid is cleared on entry to FETCH, so a partially filled line is never hit.
- Miss latency: a request in cycle 0 sees pmem_read from cycle 1. If memory returns beats back-to-back starting cycle k, the request is served (inst_resp=1) in cycle k+BEATS, provided inst_addr is held.
- inst_read deasserted, or inst_addr changed (branch redirect), during FETCH: the burst always completes; the in-flight memory transaction is never aborted. Back in IDLE the current inst_addr/inst_read are evaluated afresh and may miss again.
- pmem_resp while in IDLE is ignored; no state change.
- Gaps between beats (pmem_resp low) are allowed; beat_cnt holds.
- Reset mid-burst: everything returns to reset values immediately. pmem_read drops asynchronously. Beats still arriving after reset are ignored.
- No writes and no coherence; the line buffer is read-only.

Test Plan:
- Cold miss: reset, inst_read=1, inst_addr=0x60. Memory returns beats 0x0000_0002_0000_0001, 0x..04_..03, 0x..06_..05, 0x..08_..07 on consecutive cycles from cycle 3 → pmem_address=0x60, pmem_read high for cycles 1-6, inst_resp=1 in cycle 7 with inst_rdata=0x1.
- Hits after fill: inst_addr stepped 0x60, 0x64 … 0x7C on consecutive cycles → inst_resp=1 every cycle with data 0x1…0x8 and no pmem_read.
- Redirect mid-burst: inst_addr changes from 0x60 to 0x200 after beat 1 → burst for 0x60 completes, then a new burst at 0x200 is issued. The 0x60 line is never returned for 0x200.
- Beat gaps: pmem_resp pulses on alternate cycles → line assembles correctly and inst_resp is asserted only after the 4th beat.
- Reset after 2 of 4 beats: pmem_read low immediately. Next request to the same address misses, and a full 4-beat burst is re-issued.
- Stray pmem_resp in IDLE with line valid for 0x60 → read of 0x64 still returns the original 0x2.

Source files
------------

// File: rtl/inst_line_responder.sv
// Instruction-fetch responder backed by a single line buffer.
// Hits are answered combinationally. A miss triggers a burst read of the
// whole line from physical memory, one beat per pmem_resp.
//
// state | meaning
// IDLE  | serve hits from the line buffer, launch a burst on a miss
// FETCH | burst in flight, collect beats into the line buffer
module inst_line_responder #(
    parameter int BEAT_W = 64,
    parameter int BEATS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_read,
    input  logic [31:0]       inst_addr,
    output logic [31:0]       inst_rdata,
    output logic              inst_resp,
    output logic              pmem_read,
    output logic [31:0]       pmem_address,
    input  logic [BEAT_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int LINE_W = BEAT_W * BEATS;
    localparam int OFF    = $clog2(LINE_W / 8);
    localparam int TAG_W  = 32 - OFF;
    localparam int WORDS  = LINE_W / 32;
    localparam int IDX_W  = OFF - 2;
    localparam int CNT_W  = $clog2(BEATS);

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [LINE_W-1:0] line_q;
    logic [TAG_W-1:0]  tag_q;
    logic              line_valid;
    logic [CNT_W-1:0]  beat_cnt;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  word_idx;
    logic [31:0]       word_sel;
    logic              hit;
    logic              last_beat;
    logic              miss_start;
    logic              fill_done;
    logic              unused_addr_bits;

    assign req_tag          = inst_addr[31:OFF];
    assign word_idx         = inst_addr[OFF-1:2];
    assign unused_addr_bits = ^inst_addr[1:0];
    assign hit              = (state_q == IDLE) && inst_read && line_valid && (tag_q == req_tag);
    assign last_beat        = pmem_resp && (beat_cnt == CNT_W'(BEATS - 1));

    // Pick the addressed 32-bit word out of the line buffer.
    always_comb begin
        word_sel = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (word_idx == IDX_W'(i)) begin
                word_sel = line_q[32*i +: 32];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and fetch-side outputs; rdata is forced to zero unless a hit is served.
    always_comb begin
        state_d    = state_q;
        inst_resp  = 1'b0;
        inst_rdata = '0;
        miss_start = 1'b0;
        fill_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    inst_resp  = 1'b1;
                    inst_rdata = word_sel;
                end else if (inst_read) begin
                    miss_start = 1'b1;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                if (last_beat) begin
                    fill_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line buffer, tag and burst interface; the tag comes from the registered burst
    // address so a redirect during the burst cannot mislabel the line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_q       <= '0;
            tag_q        <= '0;
            line_valid   <= 1'b0;
            beat_cnt     <= '0;
            pmem_read    <= 1'b0;
            pmem_address <= '0;
        end else begin
            if (miss_start) begin
                pmem_address <= {req_tag, {OFF{1'b0}}};
                pmem_read    <= 1'b1;
                beat_cnt     <= '0;
                line_valid   <= 1'b0;
            end
            if (state_q == FETCH && pmem_resp) begin
                for (int b = 0; b < BEATS; b++) begin
                    if (beat_cnt == CNT_W'(b)) begin
                        line_q[BEAT_W*b +: BEAT_W] <= pmem_rdata;
                    end
                end
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            if (fill_done) begin
                line_valid <= 1'b1;
                tag_q      <= pmem_address[31:OFF];
                pmem_read  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_line_responder.sv
// Directed bench for inst_line_responder: a burst memory model answers
// pmem_read, expected instruction words go into a scoreboard queue when a
// request is driven and are popped whenever inst_resp is seen.
module tb_inst_line_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_read;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_resp;
    logic        pmem_read;
    logic [31:0] pmem_address;
    logic [63:0] pmem_rdata;
    logic        pmem_resp;

    logic [63:0] mem_data;
    logic        mem_resp;
    logic        stray_resp;
    logic        mem_busy;
    logic [31:0] last_addr = '0;
    int          gap_mode = 0;
    int          bursts = 0;
    int          mem_beats = 0;
    int          rd_cycles = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    logic        prev_rd = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] exp_q[$];

    inst_line_responder #(.BEAT_W(64), .BEATS(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_read    (inst_read),
        .inst_addr    (inst_addr),
        .inst_rdata   (inst_rdata),
        .inst_resp    (inst_resp),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    assign pmem_resp  = mem_resp | stray_resp;
    assign pmem_rdata = stray_resp ? 64'hDEAD_BEEF_DEAD_BEEF : mem_data;

    // Memory contents: line 0x60 holds words 1..8, other lines get distinct values.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] hi;
        hi = {a[31:5] - 27'd3, 5'd0};
        return hi | ({29'd0, a[4:2]} + 32'd1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Burst memory: first beat two cycles after pmem_read is seen, optional one-cycle gaps.
    initial begin
        logic [31:0] base;
        mem_resp = 1'b0;
        mem_data = '0;
        mem_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (pmem_read) begin
                mem_busy  = 1'b1;
                base      = pmem_address;
                last_addr = base;
                bursts++;
                repeat (2) @(posedge clk);
                #1;
                for (int b = 0; b < 4; b++) begin
                    mem_resp = 1'b1;
                    mem_data = {mem_word(base + 32'(8*b + 4)), mem_word(base + 32'(8*b))};
                    mem_beats++;
                    @(posedge clk);
                    #1;
                    mem_resp = 1'b0;
                    if (gap_mode != 0 && b < 3) begin
                        @(posedge clk);
                        #1;
                    end
                end
                mem_busy = 1'b0;
            end
        end
    end

    // Monitor: burst address stability and scoreboard pop on every response.
    always @(negedge clk) begin
        if (pmem_read) rd_cycles++;
        if (pmem_read && prev_rd) chk("pmem_address_stable", pmem_address, prev_addr);
        prev_rd   = pmem_read;
        prev_addr = pmem_address;
        if (inst_resp) begin
            if (exp_q.size() == 0) chk("unexpected_resp", inst_resp, 0);
            else chk("scoreboard_data", inst_rdata, exp_q.pop_front());
        end
    end

    task automatic fetch(input logic [31:0] a, output int lat);
        inst_read = 1'b1;
        inst_addr = a;
        exp_q.push_back(mem_word(a));
        lat = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (inst_resp) break;
            lat++;
        end
        chk("fetch_served", inst_resp, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        inst_read = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int r0;
        int b0;
        reset      = 1'b1;
        inst_read  = 1'b0;
        inst_addr  = '0;
        stray_resp = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_inst_resp", inst_resp, 0);
        chk("reset_pmem_read", pmem_read, 0);
        chk("reset_pmem_address", pmem_address, 0);
        chk("reset_inst_rdata", inst_rdata, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // cold miss
        r0 = rd_cycles;
        fetch(32'h60, lat);
        chk("cold_latency", lat, 7);
        chk("cold_pmem_address", last_addr, 32'h60);
        chk("cold_read_cycles", rd_cycles - r0, 6);

        // hits across the whole line on consecutive cycles
        r0 = rd_cycles;
        for (int i = 0; i < 8; i++) begin
            fetch(32'h60 + 32'(4*i), lat);
            chk("hit_latency", lat, 0);
        end
        chk("hit_no_pmem_read", rd_cycles - r0, 0);
        idle(1);
        chk("idle_inst_resp", inst_resp, 0);
        chk("idle_inst_rdata", inst_rdata, 0);

        // stray beat while idle
        stray_resp = 1'b1;
        @(posedge clk);
        #1;
        stray_resp = 1'b0;
        b0 = bursts;
        fetch(32'h64, lat);
        chk("stray_hit_latency", lat, 0);
        chk("stray_no_burst", bursts - b0, 0);

        // beats with gaps
        gap_mode = 1;
        fetch(32'h400, lat);
        chk("gap_latency", lat, 10);
        gap_mode = 0;
        fetch(32'h41C, lat);
        chk("gap_hit_latency", lat, 0);

        // redirect after beat 1: the 0x60 burst finishes, then 0x200 misses
        b0 = bursts;
        inst_read = 1'b1;
        inst_addr = 32'h60;
        repeat (5) @(posedge clk);
        #1;
        fetch(32'h200, lat);
        chk("redirect_latency", lat, 9);
        chk("redirect_pmem_address", last_addr, 32'h200);
        chk("redirect_bursts", bursts - b0, 2);

        // reset after two beats of a 0x60 burst
        idle(1);
        b0 = bursts;
        inst_read = 1'b1;
        inst_addr = 32'h60;
        repeat (5) @(posedge clk);
        #1;
        reset     = 1'b1;
        inst_read = 1'b0;
        #1;
        chk("midreset_pmem_read", pmem_read, 0);
        chk("midreset_pmem_address", pmem_address, 0);
        chk("midreset_inst_resp", inst_resp, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midreset_mem_idle", mem_busy, 0);
        fetch(32'h60, lat);
        chk("post_reset_latency", lat, 7);
        chk("post_reset_bursts", bursts - b0, 2);
        fetch(32'h7C, lat);
        chk("post_reset_hit_latency", lat, 0);
        fetch(32'h200, lat);
        chk("old_line_gone_latency", lat, 7);

        idle(2);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
